// File: rtl/mem_responder_if.sv
// mem_responder_if: lab memory bus between an initiator and mem_responder.
//
// Handshake: the initiator raises read or write together with address
// (and memIn for writes) and holds the strobe until it sees a one-cycle
// ready pulse (success) or err pulse (rejected). Dropping the strobe
// before completion aborts the access. memOut is valid in the cycle
// ready is high after a read.
//
// Build option MEM_BYTE_EN_EN adds a 4-bit byte-enable lane (be).
interface mem_responder_if;
    logic [31:0] address;
    logic [31:0] memIn;
    logic        read;
    logic        write;
`ifdef MEM_BYTE_EN_EN
    logic [3:0]  be;
`endif
    logic [31:0] memOut;
    logic        ready;
    logic        err;

`ifdef MEM_BYTE_EN_EN
    modport master (
        output address, memIn, read, write, be,
        input  memOut, ready, err
    );
    modport slave (
        input  address, memIn, read, write, be,
        output memOut, ready, err
    );
`else
    modport master (
        output address, memIn, read, write,
        input  memOut, ready, err
    );
    modport slave (
        input  address, memIn, read, write,
        output memOut, ready, err
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-organised data memory with a ready/err completion
// handshake and a programmable number of wait states.
//
// An access is sampled in IDLE, optionally spends WAIT_STATES cycles in
// WAIT, then completes in a single DONE cycle which commits the write or
// registers the read data and raises ready (or err for a rejected access).
//
// Build option: define MEM_BYTE_EN_EN to add per-byte write enables.
module mem_responder #(
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus,
    output logic [1:0]     dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    // One past the last valid byte address, widened so a BASE near the
    // top of the address space cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic             wr_q;
    logic             err_q;
`ifdef MEM_BYTE_EN_EN
    logic [3:0]       be_q;
`endif

    logic [31:0]      mem [DEPTH];

    logic             req;
    logic             req_bad;
    logic             strobe_held;
    logic [IDX_W-1:0] mem_idx;

    assign req     = bus.read | bus.write;
    assign mem_idx = IDX_W'((addr_q - BASE) >> 2);

    // The strobe that belongs to the access in flight; its loss aborts.
    assign strobe_held = wr_q ? bus.write : bus.read;

    assign dbg_state = state;

    // Classify the live request as rejected: misaligned, outside the
    // window, or both strobes at once.
    always_comb begin
        req_bad = 1'b0;
        if (bus.address[1:0] != 2'b00)
            req_bad = 1'b1;
        if ({1'b0, bus.address} < {1'b0, BASE})
            req_bad = 1'b1;
        if ({1'b0, bus.address} >= LIMIT)
            req_bad = 1'b1;
        if (bus.read && bus.write)
            req_bad = 1'b1;
    end

    // Control FSM, request latches and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
`ifdef MEM_BYTE_EN_EN
            be_q       <= '0;
`endif
            bus.memOut <= '0;
            bus.ready  <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q <= bus.address;
                        data_q <= bus.memIn;
                        wr_q   <= bus.write;
                        err_q  <= req_bad;
`ifdef MEM_BYTE_EN_EN
                        be_q   <= bus.be;
`endif
                        // Rejected accesses skip the wait states entirely.
                        if (req_bad || (WAIT_STATES == 0)) begin
                            state <= S_DONE;
                        end else begin
                            cnt   <= WAIT_LOAD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!strobe_held) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (err_q) begin
                        bus.err <= 1'b1;
                    end else begin
                        bus.ready <= 1'b1;
                        if (!wr_q)
                            bus.memOut <= mem[mem_idx];
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage write port; the array is deliberately not reset, and a reset
    // coinciding with DONE must not commit the write.
    always_ff @(posedge clk) begin
        if (!reset && (state == S_DONE) && !err_q && wr_q) begin
`ifdef MEM_BYTE_EN_EN
            for (int i = 0; i < 4; i++) begin
                if (be_q[i])
                    mem[mem_idx][8*i +: 8] <= data_q[8*i +: 8];
            end
`else
            mem[mem_idx] <= data_q;
`endif
        end
    end

    // Completion pulses are mutually exclusive.
    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(bus.ready && bus.err));
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder
// against a word/byte-level reference memory held in the bench.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 64;
`ifdef MEM_BYTE_EN_EN
  localparam int          WS    = 0;
`else
  localparam int          WS    = 2;
`endif
  localparam int          BUDGET = 40;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  mem_responder_if bus();

  mem_responder #(
    .BASE        (BASE),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] model_mem   [DEPTH];
  logic [3:0]  model_known [DEPTH];
  logic [31:0] exp_out;
  logic [3:0]  exp_mask;
  logic [31:0] exp_q[$];
  logic [3:0]  mask_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m32(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic bit is_bad(input bit rd, input bit wr, input logic [31:0] a);
    longint ua;
    longint lo;
    ua = longint'(a);
    lo = longint'(BASE);
    return (ua % 4 != 0) || (ua < lo) || (ua >= lo + 4 * DEPTH) || (rd && wr);
  endfunction

  task automatic check_memout(input string tag);
    if (exp_mask != 4'h0)
      check({tag, "/memOut"}, bus.memOut & m32(exp_mask), exp_out & m32(exp_mask));
  endtask

  // ---------------- driver tasks ----------------
  // One complete access: strobe held until a pulse, then released.
  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    int          k;
    bit          sr;
    bit          se;
    bit          bad;
    int          idx;
    logic [3:0]  beff;
`ifdef MEM_BYTE_EN_EN
    beff = b;
`else
    beff = 4'hf;
    if (b == 4'h0) beff = 4'hf;
`endif
    bad = is_bad(rd, wr, a);

    @(negedge clk);
    bus.address = a;
    bus.memIn   = d;
    bus.read    = rd;
    bus.write   = wr;
`ifdef MEM_BYTE_EN_EN
    bus.be      = b;
`endif
    @(posedge clk);
    k  = 0;
    sr = 1'b0;
    se = 1'b0;
    for (int i = 1; i <= BUDGET && k == 0; i++) begin
      @(negedge clk);
      bus.address = $urandom;
      bus.memIn   = $urandom;
      @(posedge clk);
      #1;
      if (bus.ready && bus.err)
        check({tag, "/both_pulses"}, 32'(bus.ready & bus.err), 32'd0);
      if (bus.ready || bus.err) begin
        k  = i;
        sr = bus.ready;
        se = bus.err;
      end
    end

    // reference model: apply the access by the rules
    if (!bad) begin
      idx = int'((a - BASE) / 4);
      if (wr) begin
        for (int i = 0; i < 4; i++) begin
          if (beff[i]) begin
            model_mem[idx][8*i +: 8] = d[8*i +: 8];
            model_known[idx][i]      = 1'b1;
          end
        end
      end else begin
        exp_q.push_back(model_mem[idx]);
        mask_q.push_back(model_known[idx]);
      end
    end
    if (exp_q.size() > 0) begin
      exp_out  = exp_q.pop_front();
      exp_mask = mask_q.pop_front();
    end

    check({tag, "/latency"}, k, bad ? 1 : WS + 1);
    check({tag, "/ready"}, 32'(sr), 32'(!bad));
    check({tag, "/err"}, 32'(se), 32'(bad));
    check_memout(tag);

    @(negedge clk);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  // Write dropped after one WAIT cycle: no pulse may follow.
  task automatic abort_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    bit pulse;
    @(negedge clk);
    bus.address = a;
    bus.memIn   = d;
    bus.write   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.write = 1'b0;
    pulse = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.ready || bus.err) pulse = 1'b1;
    end
    check({tag, "/pulse"}, 32'(pulse), 32'd0);
    check_memout(tag);
  endtask

  // Reset asserted while a write is in WAIT.
  task automatic reset_mid_wait(input string tag, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.memIn   = d;
    bus.write   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, "/memOut"}, bus.memOut, 32'd0);
    check({tag, "/ready"}, 32'(bus.ready), 32'd0);
    check({tag, "/err"}, 32'(bus.err), 32'd0);
    exp_out  = 32'd0;
    exp_mask = 4'hf;
    @(negedge clk);
    bus.write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Read held across two completions: spacing is WS+2 edges.
  task automatic held_read(input string tag, input logic [31:0] a);
    int p1;
    int p2;
    int idx;
    @(negedge clk);
    bus.address = a;
    bus.read    = 1'b1;
    @(posedge clk);
    p1 = 0;
    p2 = 0;
    for (int i = 1; i <= BUDGET && p2 == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin
        if (p1 == 0) p1 = i;
        else p2 = i;
      end
    end
    @(negedge clk);
    bus.read = 1'b0;
    idx      = int'((a - BASE) / 4);
    exp_out  = model_mem[idx];
    exp_mask = model_known[idx];
    check({tag, "/first"}, p1, WS + 1);
    check({tag, "/period"}, p2 - p1, WS + 2);
    check_memout(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    bit          rd;
    bit          wr;
    int          sel;

    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = 32'd0;
      model_known[i] = 4'h0;
    end
    reset       = 1'b1;
    bus.address = '0;
    bus.memIn   = '0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
`ifdef MEM_BYTE_EN_EN
    bus.be      = 4'hf;
`endif
    repeat (3) @(negedge clk);
    check("reset/memOut", bus.memOut, 32'd0);
    check("reset/ready", 32'(bus.ready), 32'd0);
    check("reset/err", 32'(bus.err), 32'd0);
    exp_out  = 32'd0;
    exp_mask = 4'hf;
    reset    = 1'b0;
    @(negedge clk);

    access("w16", 0, 1, 32'd16, 32'h1234_5678, 4'hf);
    access("r16", 1, 0, 32'd16, 32'h0, 4'hf);
`ifdef MEM_BYTE_EN_EN
    access("w16_be5", 0, 1, 32'd16, 32'hffff_ffff, 4'b0101);
    access("r16_be5", 1, 0, 32'd16, 32'h0, 4'hf);
    check("be5/value", bus.memOut, 32'h12ff_56ff);
    access("w16_be0", 0, 1, 32'd16, 32'h0000_0000, 4'b0000);
    access("r16_be0", 1, 0, 32'd16, 32'h0, 4'hf);
    access("w20", 0, 1, 32'd20, 32'h89ab_cdef, 4'hf);
    access("r20", 1, 0, 32'd20, 32'h0, 4'h0);
`else
    access("w20", 0, 1, 32'd20, 32'h89ab_cdef, 4'hf);
    access("r24", 1, 0, 32'd24, 32'h0, 4'hf);
    access("r16b", 1, 0, 32'd16, 32'h0, 4'hf);
    access("r20", 1, 0, 32'd20, 32'h0, 4'hf);
    check("r20/value", bus.memOut, 32'h89ab_cdef);
`endif
    access("r18_misalign", 1, 0, 32'd18, 32'h0, 4'hf);
    access("r256_range", 1, 0, 32'd256, 32'h0, 4'hf);
    access("rw16_both", 1, 1, 32'd16, 32'hffff_0000, 4'hf);
    access("w252_last", 0, 1, 32'd252, 32'h0bad_f00d, 4'hf);
    access("r252_last", 1, 0, 32'd252, 32'h0, 4'hf);
    access("r16c", 1, 0, 32'd16, 32'h0, 4'hf);
`ifndef MEM_BYTE_EN_EN
    check("r16c/value", bus.memOut, 32'h1234_5678);
    abort_write("abort16", 32'd16, 32'hdead_beef);
    access("r16_after_abort", 1, 0, 32'd16, 32'h0, 4'hf);
    reset_mid_wait("rst20", 32'd20, 32'hcafe_f00d);
    access("r20_after_rst", 1, 0, 32'd20, 32'h0, 4'hf);
`endif
    held_read("held16", 32'd16);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      a   = BASE + 32'(4 * $urandom_range(0, 15));
      wr  = 1'($urandom_range(0, 1));
      rd  = !wr;
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      if (sel == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
      if (sel == 2) begin
        rd = 1'b1;
        wr = 1'b1;
      end
      access("rnd", rd, wr, a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-organised data memory that responds to the lab bus: `address`, `memIn`, `read`, `write`, `memOut`.
- Adds a `ready`/`err` completion handshake and a programmable wait-state latency.
- Sits behind any initiator (testbench, CPU load/store stage) that drives byte addresses and holds strobes until completion.

Parameters:
- BASE, 32'h0000_0000, byte address of word 0.
- DEPTH, 64, number of 32-bit words stored.
- WAIT_STATES, 2, cycles spent in WAIT before completion (0 legal).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  32  byte address of access.
- memIn  input  32  write data.
- read  input  1  read strobe, held until ready/err.
- write  input  1  write strobe, held until ready/err.
- memOut  output  32  read data, registered.
- ready  output  1  one-cycle completion pulse, successful access.
- err  output  1  one-cycle completion pulse, rejected access.

Behaviour:
- Reset (async, active-high): state=IDLE, memOut=0, ready=0, err=0, wait counter=0. Storage array is not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If read or write is high, latch address, memIn and operation, then check the request.
  - Error cases: address[1:0]!=0; address<BASE; address>=BASE+4*DEPTH; read&&write both high.
  - Any error -> DONE with err pending and no array access.
  - Otherwise: WAIT_STATES==0 -> DONE; else load counter=WAIT_STATES-1 -> WAIT.
- WAIT:
  - Counter decrements each cycle; at 0 -> DONE.
  - If the active strobe deasserts during WAIT -> IDLE (abort). No write is performed and memOut is unchanged.
- DONE (one cycle):
  - Write: array[(addr-BASE)>>2] <= latched memIn.
  - Read: memOut <= array word.
  - ready=1 (or err=1 for a rejected access) in this same cycle; memOut is valid in this same cycle.
  - Next state IDLE.
- Latency, strobe sampled high in IDLE at edge N: completion pulse at edge N+WAIT_STATES+1. Error pulse at edge N+1 regardless of WAIT_STATES.
- Back-to-back: a strobe still high in IDLE after DONE starts a new access. A continuously held read re-reads every WAIT_STATES+2 cycles.
- memOut holds the last successful read data through writes, errors and aborts.
- Read of a never-written word returns the array's uninitialised contents; the bench must not check those values.
- Latched address/data are used, not the live inputs; changes to the inputs during WAIT are ignored.
- reset mid-WAIT or mid-DONE: immediate return to IDLE, no write committed, outputs forced to reset values.
- ready and err are never high together.

Optional Feature:
- MEM_BYTE_EN_EN defined:
  - Adds port `be  input  4`, latched in IDLE with the other request fields.
  - Writes update only the bytes whose be bit is 1; be[0]=bits 7:0.
  - Write with be==0 completes with ready and no change.
  - Reads ignore be.
- MEM_BYTE_EN_EN undefined: no `be` port; writes are full-word.

Test Plan:
- WAIT_STATES=2: write 32'h12345678 @16; hold write until ready -> ready pulse 3 edges after strobe sampled. Then read @16 -> memOut=32'h12345678 in the ready cycle.
- Write 32'h89abcdef @20, then read @16 and @20 -> 32'h12345678, 32'h89abcdef. Read @24 (unwritten) -> ready pulse only, data not checked.
- Read @18 (misaligned), read @256 (out of range, DEPTH=64), read+write both high @16 -> err pulse at N+1 each time. Array unchanged, memOut still 32'h89abcdef.
- Write 32'hdeadbeef @16, write dropped after 1 WAIT cycle -> no ready/err pulse. Subsequent read @16 returns 32'h12345678.
- Assert reset during WAIT of a write of 32'hcafef00d @20 -> memOut=0, ready=0, err=0 immediately. Next read @20 returns 32'h89abcdef.
- MEM_BYTE_EN_EN, WAIT_STATES=0: write 32'hffffffff be=4'b0101 over 32'h12345678 @16 -> read returns 32'h12ff56ff, ready at N+1.
